// File: rtl/microcode_sequencer.sv
// rtl/microcode_sequencer.sv - per-opcode microcode sequencer with call stack and branches
//
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   start, opcode             segment request from decode; opcode all-ones requests halt
//   flags                     datapath condition flags tested by BRT/BRF
//   ctrl, eos                 control word and end-of-segment strobe (RUN only)
//   busy, halted, err         state indicators (RUN, HALT, ERR)
//   mem_we/mem_waddr/mem_wdata  microcode store write port
//   seg_we/seg_widx/seg_waddr   segment table write port (marks entry valid)
//
// Microword layout: {op[2:0], csel, target[ADDR_W-1:0], eos, ctrl}
module microcode_sequencer #(
  parameter int CTRL_W      = 32,
  parameter int ADDR_W      = 8,
  parameter int SEG_W       = 6,
  parameter int STACK_DEPTH = 8,
  parameter int NFLAGS      = 4,
  localparam int CSEL_W     = (NFLAGS > 1) ? $clog2(NFLAGS) : 1,
  localparam int MW         = 3 + CSEL_W + ADDR_W + 1 + CTRL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [SEG_W-1:0]  opcode,
  input  logic [NFLAGS-1:0] flags,
  output logic [CTRL_W-1:0] ctrl,
  output logic              eos,
  output logic              busy,
  output logic              halted,
  output logic              err,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_waddr,
  input  logic [MW-1:0]     mem_wdata,
  input  logic              seg_we,
  input  logic [SEG_W-1:0]  seg_widx,
  input  logic [ADDR_W-1:0] seg_waddr
);

  localparam int SP_W = $clog2(STACK_DEPTH + 1);
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

  localparam logic [2:0] OP_NEXT = 3'd0;
  localparam logic [2:0] OP_JMP  = 3'd1;
  localparam logic [2:0] OP_CALL = 3'd2;
  localparam logic [2:0] OP_BRT  = 3'd3;
  localparam logic [2:0] OP_BRF  = 3'd4;
  localparam logic [2:0] OP_HALT = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t state, state_next;

  logic [MW-1:0]          mem [2**ADDR_W];
  logic [ADDR_W-1:0]      seg_start [2**SEG_W];
  logic [2**SEG_W-1:0]    seg_valid;
  // Sized to the full sp index range so sp indexes it without width games;
  // entries at and above STACK_DEPTH are never written.
  logic [ADDR_W-1:0]      stack [2**SP_W];
  logic [SP_W-1:0]        sp;
  logic [ADDR_W-1:0]      pc, pc_next, pc_inc;
  logic                   push, pop;

  logic [MW-1:0]          w;
  logic [2:0]             w_op;
  logic [CSEL_W-1:0]      w_csel;
  logic [ADDR_W-1:0]      w_target;
  logic                   w_eos;
  logic [CTRL_W-1:0]      w_ctrl;
  logic                   flag_bit;

  assign w        = mem[pc];
  assign w_op     = w[MW-1 -: 3];
  assign w_csel   = w[CTRL_W+1+ADDR_W +: CSEL_W];
  assign w_target = w[CTRL_W+1 +: ADDR_W];
  assign w_eos    = w[CTRL_W];
  assign w_ctrl   = w[CTRL_W-1:0];
  assign pc_inc   = pc + ADDR_W'(1);

  // Selectors that name a nonexistent flag read as 0.
  always_comb begin
    flag_bit = 1'b0;
    for (int i = 0; i < NFLAGS; i++) begin
      if (w_csel == CSEL_W'(i)) flag_bit = flags[i];
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state and sequencing decisions
  always_comb begin
    state_next = state;
    pc_next    = pc;
    push       = 1'b0;
    pop        = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (&opcode) begin
            state_next = S_HALT;
          end else if (!seg_valid[opcode]) begin
            state_next = S_ERR;
          end else begin
            pc_next    = seg_start[opcode];
            state_next = S_RUN;
          end
        end
      end
      S_RUN: begin
        // The eos bit takes priority over whatever the op field says.
        if (w_eos) begin
          if (sp != '0) begin
            pop     = 1'b1;
            pc_next = stack[sp - SP_W'(1)];
          end else begin
            state_next = S_IDLE;
          end
        end else begin
          case (w_op)
            OP_JMP:  pc_next = w_target;
            OP_CALL: begin
              if (sp == SP_FULL) begin
                state_next = S_ERR;
              end else begin
                push    = 1'b1;
                pc_next = w_target;
              end
            end
            OP_BRT:  pc_next = flag_bit ? w_target : pc_inc;
            OP_BRF:  pc_next = !flag_bit ? w_target : pc_inc;
            OP_HALT: state_next = S_HALT;
            default: pc_next = pc_inc;
          endcase
        end
      end
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    ctrl   = '0;
    eos    = 1'b0;
    busy   = 1'b0;
    halted = 1'b0;
    err    = 1'b0;
    case (state)
      S_RUN: begin
        busy = 1'b1;
        ctrl = w_ctrl;
        eos  = w_eos && (sp == '0);
      end
      S_HALT:  halted = 1'b1;
      S_ERR:   err = 1'b1;
      default: ;
    endcase
  end

  // pc, call stack and segment table
  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= '0;
      sp        <= '0;
      seg_valid <= '0;
    end else begin
      pc <= pc_next;
      if (push) begin
        stack[sp] <= pc_inc;
        sp        <= sp + SP_W'(1);
      end else if (pop) begin
        sp <= sp - SP_W'(1);
      end
      // Registered, so a start in the same cycle still sees the old entry.
      if (seg_we) begin
        seg_valid[seg_widx] <= 1'b1;
        seg_start[seg_widx] <= seg_waddr;
      end
    end
  end

  // Microcode store; contents survive reset.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) mem[mem_waddr] <= mem_wdata;
  end

endmodule
